// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state codes and master ids.
// Policy macro DMEM_ARB_RR_EN (round-robin) is consumed by dmem_arb_pick.
package dmem_arbiter_pkg;

    typedef logic mid_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam mid_t MID_M0 = 1'b0;
    localparam mid_t MID_M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational 2-way picker for dmem_arbiter.
// Default: fixed priority (m0 wins). With DMEM_ARB_RR_EN defined: round-robin on ties.
module dmem_arb_pick
    import dmem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  mid_t last_grant,
    output logic valid,
    output mid_t winner_id
);

    assign valid = req0 | req1;

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        winner_id = MID_M0;
        if (req0 && req1) begin
            // Tie goes to whoever was not served last.
            winner_id = (last_grant == MID_M0) ? MID_M1 : MID_M0;
        end else if (req1) begin
            winner_id = MID_M1;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign winner_id = req0 ? MID_M0 : MID_M1;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-ported data memory; one access in flight.
// Arbitration policy selected by DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    logic [0:0]        state_q, state_d;
    mid_t              gid_q, gid_d;
    mid_t              last_grant_q, last_grant_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
    logic [1:0]        gnt;

    logic              pick_valid;
    mid_t              pick_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    dmem_arb_pick u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner_id  (pick_id)
    );

    assign sel_we    = (pick_id == MID_M1) ? m1_we    : m0_we;
    assign sel_addr  = (pick_id == MID_M1) ? m1_addr  : m0_addr;
    assign sel_wdata = (pick_id == MID_M1) ? m1_wdata : m0_wdata;

    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        last_grant_d = last_grant_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d      = ST_ACCESS;
                    gid_d        = pick_id;
                    last_grant_d = pick_id;
                    mem_read_d   = ~sel_we;
                    mem_write_d  = sel_we;
                    mem_addr_d   = sel_addr;
                    mem_wdata_d  = sel_we ? sel_wdata : '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is captured at the edge that ends ACCESS and held until the next read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam mid_t ID = (gi == 1) ? MID_M1 : MID_M0;
            assign gnt[gi]      = (state_q == ST_ACCESS) && (gid_q == ID);
            assign rvalid_d[gi] = gnt[gi] && mem_read_q;
            assign rdata_d[gi]  = rvalid_d[gi] ? mem_rdata : rdata_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gid_q        <= MID_M0;
            last_grant_q <= MID_M1;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rvalid_q     <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
        end else begin
            state_q      <= state_d;
            gid_q        <= gid_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rvalid_q     <= rvalid_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed phases plus random traffic against a
// transaction-level reference model; honours DMEM_ARB_RR_EN for the expected policy.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int gap; } tx_t;
    typedef struct { int cyc; bit id; bit we; logic [31:0] addr; logic [31:0] wdata; } gexp_t;
    typedef struct { int cyc; logic [31:0] data; } rexp_t;

    tx_t   txq0[$], txq1[$];
    gexp_t gq[$];
    rexp_t rq0[$], rq1[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit in_rst = 1'b1;

    // Memory behind the arbiter: combinational read, write at clock edge.
    logic [31:0] emu_mem [0:63];
    logic [31:0] ref_mem [0:63];
    initial for (int i = 0; i < 64; i++) begin emu_mem[i] = '0; ref_mem[i] = '0; end
    assign mem_rdata = emu_mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) emu_mem[mem_addr[7:2]] <= mem_wdata;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        in_rst <= !rst_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_gnt(input int m);
        bit got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if ((m == 0) ? m0_gnt : m1_gnt) begin got = 1'b1; break; end
        end
        total++;
        if (!got) begin bad++; $display("FAIL gnt_timeout master=%0d got=0 expected=1", m); end
    endtask

    // Master drivers: hold a request until granted, then present the next one or drop req.
    initial begin : drv0
        tx_t t;
        @(posedge clk); #1;
        forever begin
            if (txq0.size() == 0) begin
                m0_req = 1'b0; @(posedge clk); #1;
            end else begin
                t = txq0.pop_front();
                if (t.gap > 0) begin m0_req = 1'b0; repeat (t.gap) @(posedge clk); #1; end
                m0_req = 1'b1; m0_we = t.we; m0_addr = t.addr; m0_wdata = t.wdata;
                wait_gnt(0);
                @(posedge clk); #1;
            end
        end
    end

    initial begin : drv1
        tx_t t;
        @(posedge clk); #1;
        forever begin
            if (txq1.size() == 0) begin
                m1_req = 1'b0; @(posedge clk); #1;
            end else begin
                t = txq1.pop_front();
                if (t.gap > 0) begin m1_req = 1'b0; repeat (t.gap) @(posedge clk); #1; end
                m1_req = 1'b1; m1_we = t.we; m1_addr = t.addr; m1_wdata = t.wdata;
                wait_gnt(1);
                @(posedge clk); #1;
            end
        end
    end

    // Reference model: decides who is served next from the request lines and the policy.
    initial begin : model
        int  acc_cyc = -10;
        bit  lg = 1'b1;
        bit  w;
        gexp_t g;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_cyc = -10;
                lg = 1'b1;
                while (rq0.size() > 0 && rq0[$].cyc > cyc) void'(rq0.pop_back());
                while (rq1.size() > 0 && rq1[$].cyc > cyc) void'(rq1.pop_back());
                while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
            end else if (acc_cyc != cyc && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
                    w = !lg;
`else
                    w = 1'b0;
`endif
                end else begin
                    w = !m0_req;
                end
                lg = w;
                acc_cyc = cyc + 1;
                g.cyc = cyc + 1; g.id = w;
                g.we = w ? m1_we : m0_we;
                g.addr = w ? m1_addr : m0_addr;
                g.wdata = w ? m1_wdata : m0_wdata;
                gq.push_back(g);
                if (g.we) ref_mem[g.addr[7:2]] = g.wdata;
                else if (w) rq1.push_back('{cyc + 2, ref_mem[g.addr[7:2]]});
                else rq0.push_back('{cyc + 2, ref_mem[g.addr[7:2]]});
            end
        end
    end

    // Monitor: compares every cycle's outputs with what the scoreboard expects.
    initial begin : monitor
        gexp_t e;
        logic [31:0] held0 = '0, held1 = '0;
        bit exp0, exp1;
        forever begin
            @(negedge clk);
            if (in_rst) begin
                chk("rst_ctrl", {57'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mem_read, mem_write}, 64'd0);
                chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
                chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
                held0 = '0; held1 = '0;
            end else begin
                if (gq.size() > 0 && gq[0].cyc == cyc) begin
                    e = gq.pop_front();
                    chk("gnt", {62'd0, m0_gnt, m1_gnt}, e.id ? 64'd1 : 64'd2);
                    chk("busy", {63'd0, busy}, 64'd1);
                    chk("mem_rw", {62'd0, mem_read, mem_write}, e.we ? 64'd1 : 64'd2);
                    chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
                    chk("mem_wdata", {32'd0, mem_wdata}, e.we ? {32'd0, e.wdata} : 64'd0);
                end else begin
                    chk("idle", {59'd0, m0_gnt, m1_gnt, busy, mem_read, mem_write}, 64'd0);
                end
                exp0 = (rq0.size() > 0 && rq0[0].cyc == cyc);
                exp1 = (rq1.size() > 0 && rq1[0].cyc == cyc);
                if (exp0) held0 = rq0.pop_front().data;
                if (exp1) held1 = rq1.pop_front().data;
                chk("m0_rvalid", {63'd0, m0_rvalid}, {63'd0, exp0});
                chk("m1_rvalid", {63'd0, m1_rvalid}, {63'd0, exp1});
                chk("m0_rdata", {32'd0, m0_rdata}, {32'd0, held0});
                chk("m1_rdata", {32'd0, m1_rdata}, {32'd0, held1});
            end
        end
    end

    a_excl: assert property (@(posedge clk) !(mem_read && mem_write))
        else $error("mem_read and mem_write high together");
    a_gnt_busy: assert property (@(posedge clk) (m0_gnt || m1_gnt) |-> busy)
        else $error("grant outside ACCESS");

    task automatic wait_idle();
        bit done = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk); #3;
            if (txq0.size() == 0 && txq1.size() == 0 && !m0_req && !m1_req &&
                gq.size() == 0 && rq0.size() == 0 && rq1.size() == 0) begin
                done = 1'b1; break;
            end
        end
        total++;
        if (!done) begin bad++; $display("FAIL idle_timeout got=busy expected=idle"); end
    endtask

    initial begin : main
        tx_t t;
        // Both masters request through reset; m0 must win the first slot.
        txq0.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 0});
        txq1.push_back('{1'b0, 32'h8, 32'h0, 0});
        repeat (3) @(posedge clk); #1 rst_n = 1'b1;
        wait_idle();

        txq0.push_back('{1'b0, 32'h10, 32'h0, 0});
        wait_idle();
        chk("t2_readback", {32'd0, m0_rdata}, 64'hDEADBEEF);

        for (int i = 0; i < 6; i++) begin
            txq0.push_back('{1'b0, 32'h4, 32'h0, 0});
            txq1.push_back('{1'b0, 32'h8, 32'h0, 0});
        end
        wait_idle();

        txq1.push_back('{1'b1, 32'h20, 32'h11, 0});
        txq1.push_back('{1'b1, 32'h24, 32'h22, 0});
        txq1.push_back('{1'b0, 32'h20, 32'h0, 0});
        txq1.push_back('{1'b0, 32'h24, 32'h0, 0});
        wait_idle();
        chk("t4_last_read", {32'd0, m1_rdata}, 64'h22);

        for (int i = 0; i < 150; i++) begin
            t.we = 1'($urandom_range(0, 1)); t.addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            t.wdata = $urandom; t.gap = $urandom_range(0, 3);
            txq0.push_back(t);
            t.we = 1'($urandom_range(0, 1)); t.addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            t.wdata = $urandom; t.gap = $urandom_range(0, 3);
            txq1.push_back(t);
        end
        wait_idle();

        // Reset lands on the edge that ends an m1 write access; the write must still land.
        txq1.push_back('{1'b1, 32'h30, 32'h55, 0});
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk); #2;
                if (m1_gnt) begin seen = 1'b1; break; end
            end
            total++;
            if (!seen) begin bad++; $display("FAIL t5_gnt got=0 expected=1"); end
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk); #2;
        chk("t5_mem_commit", {32'd0, emu_mem[12]}, 64'h55);
        chk("t5_idle", {62'd0, busy, m1_rvalid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
